// File: rtl/csr_pkg.sv
// Shared CSR addresses, funct3 op encodings and the trap-vector alignment mask
// for the machine-mode CSR file.
package csr_pkg;

    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    typedef enum logic [2:0] {
        CSR_OP_RW  = 3'b001,
        CSR_OP_RS  = 3'b010,
        CSR_OP_RC  = 3'b011,
        CSR_OP_RWI = 3'b101,
        CSR_OP_RSI = 3'b110,
        CSR_OP_RCI = 3'b111
    } csr_op_e;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with independently writable halves; a write to one half
// takes priority over the increment carrying into it.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 64'd0;
        end else if (wr_lo) begin
            q[31:0] <= wdata;
        end else if (wr_hi) begin
            // Low half keeps counting; its carry out is dropped this cycle.
            q[63:32] <= wdata;
            q[31:0]  <= q[31:0] + {31'd0, inc};
        end else begin
            q <= q + {63'd0, inc};
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: combinational read-old/legality decode, registered
// read-modify-write, and the mcycle/minstret counters.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CSRWrite,
    input  logic [2:0]  funct3,
    input  logic [11:0] CSRAddr,
    input  logic [4:0]  Rs1Idx,
    input  logic [31:0] Rs1Data,
    input  logic        InstrRetired,
    output logic [31:0] CSRRead,
    output logic        IllegalCSR
);

    logic [31:0] mtvec, mscratch, mepc, mcause;
    logic [63:0] mcycle, minstret;
    logic        implemented, read_only;
    logic [31:0] operand, new_value;
    logic        suppress, bad_op, wr_en;

    always_comb begin
        CSRRead     = 32'd0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (CSRAddr)
            CSR_MTVEC:     CSRRead = mtvec;
            CSR_MSCRATCH:  CSRRead = mscratch;
            CSR_MEPC:      CSRRead = mepc;
            CSR_MCAUSE:    CSRRead = mcause;
            CSR_MCYCLE:    CSRRead = mcycle[31:0];
            CSR_MINSTRET:  CSRRead = minstret[31:0];
            CSR_MCYCLEH:   CSRRead = mcycle[63:32];
            CSR_MINSTRETH: CSRRead = minstret[63:32];
            CSR_CYCLE:     begin CSRRead = mcycle[31:0];    read_only = 1'b1; end
            CSR_INSTRET:   begin CSRRead = minstret[31:0];  read_only = 1'b1; end
            CSR_CYCLEH:    begin CSRRead = mcycle[63:32];   read_only = 1'b1; end
            CSR_INSTRETH:  begin CSRRead = minstret[63:32]; read_only = 1'b1; end
            default:       implemented = 1'b0;
        endcase
    end

    assign operand = funct3[2] ? {27'd0, Rs1Idx} : Rs1Data;

    always_comb begin
        new_value = CSRRead;
        case (csr_op_e'(funct3))
            CSR_OP_RW,  CSR_OP_RWI: new_value = operand;
            CSR_OP_RS,  CSR_OP_RSI: new_value = CSRRead | operand;
            CSR_OP_RC,  CSR_OP_RCI: new_value = CSRRead & ~operand;
            default:                new_value = CSRRead;
        endcase
    end

    // Set/clear with x0/zimm=0 is a pure read, so it is legal on read-only aliases.
    assign suppress   = funct3[1] && (Rs1Idx == 5'd0);
    assign bad_op     = (funct3[1:0] == 2'b00);
    assign IllegalCSR = CSRWrite && (bad_op || !implemented || (read_only && !suppress));
    assign wr_en      = CSRWrite && !IllegalCSR && !suppress;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec    <= MTVEC_RESET & ALIGN_MASK;
            mscratch <= 32'd0;
            mepc     <= 32'd0;
            mcause   <= 32'd0;
        end else if (wr_en) begin
            case (CSRAddr)
                CSR_MTVEC:    mtvec    <= new_value & ALIGN_MASK;
                CSR_MSCRATCH: mscratch <= new_value;
                CSR_MEPC:     mepc     <= new_value & ALIGN_MASK;
                CSR_MCAUSE:   mcause   <= new_value;
                default:      ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (wr_en && (CSRAddr == CSR_MCYCLE)),
        .wr_hi (wr_en && (CSRAddr == CSR_MCYCLEH)),
        .wdata (new_value),
        .q     (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (InstrRetired),
        .wr_lo (wr_en && (CSRAddr == CSR_MINSTRET)),
        .wr_hi (wr_en && (CSRAddr == CSR_MINSTRETH)),
        .wdata (new_value),
        .q     (minstret)
    );

endmodule

// File: tb/tb_csr_unit.sv
// Directed and randomized bench for csr_unit against a behavioural CSR model.
`timescale 1ns/1ps
module tb_csr_unit;

    localparam logic [31:0] MTV_RST = 32'h8000_0107;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CSRWrite;
    logic [2:0]  funct3;
    logic [11:0] CSRAddr;
    logic [4:0]  Rs1Idx;
    logic [31:0] Rs1Data;
    logic        InstrRetired;
    logic [31:0] CSRRead;
    logic        IllegalCSR;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;

    logic [31:0] rdv;
    logic        ilv;

    logic [11:0] addrs [15] = '{12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                                12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82,
                                12'h123, 12'h306, 12'hB01};

    csr_unit #(.MTVEC_RESET(MTV_RST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .CSRWrite     (CSRWrite),
        .funct3       (funct3),
        .CSRAddr      (CSRAddr),
        .Rs1Idx       (Rs1Idx),
        .Rs1Data      (Rs1Data),
        .InstrRetired (InstrRetired),
        .CSRRead      (CSRRead),
        .IllegalCSR   (IllegalCSR)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mtvec    = MTV_RST & 32'hFFFF_FFFC;
        m_mscratch = 0;
        m_mepc     = 0;
        m_mcause   = 0;
        m_mcycle   = 0;
        m_minstret = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a, output bit impl, output bit ro);
        impl = 1;
        ro   = (a >= 12'hC00);
        case (a)
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_mcycle[31:0];
            12'hB80, 12'hC80: return m_mcycle[63:32];
            12'hB02, 12'hC02: return m_minstret[31:0];
            12'hB82, 12'hC82: return m_minstret[63:32];
            default: begin impl = 0; ro = 0; return 32'd0; end
        endcase
    endfunction

    // One instruction cycle: drive at the falling edge, check the combinational
    // outputs against the model, then apply the model update at the rising edge.
    task automatic cyc(input logic w, input logic [2:0] f, input logic [11:0] a,
                       input logic [4:0] i, input logic [31:0] d, input logic r,
                       output logic [31:0] rd_o, output logic ill_o);
        bit          impl, ro, sup, validop, ill, do_wr;
        logic [31:0] old, opnd, nv;
        logic [63:0] c_next, i_next;
        CSRWrite = w; funct3 = f; CSRAddr = a; Rs1Idx = i; Rs1Data = d; InstrRetired = r;
        #1;
        old     = m_read(a, impl, ro);
        opnd    = f[2] ? {27'd0, i} : d;
        sup     = (f == 3'd2 || f == 3'd3 || f == 3'd6 || f == 3'd7) && (i == 0);
        validop = !(f == 3'd0 || f == 3'd4);
        ill     = w && (!validop || !impl || (ro && !sup));
        do_wr   = w && !ill && !sup;
        if (f == 3'd1 || f == 3'd5)      nv = opnd;
        else if (f == 3'd2 || f == 3'd6) nv = old | opnd;
        else                              nv = old & ~opnd;
        rd_o  = CSRRead;
        ill_o = IllegalCSR;
        chk32($sformatf("read_%h", a), CSRRead, old);
        chk32($sformatf("illegal_%h_f%0d", a, f), {31'd0, IllegalCSR}, {31'd0, ill});
        @(posedge clk);
        c_next = m_mcycle + 64'd1;
        i_next = m_minstret + (r ? 64'd1 : 64'd0);
        if (do_wr) begin
            case (a)
                12'h305: m_mtvec    = nv & 32'hFFFF_FFFC;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause   = nv;
                12'hB00: c_next = {m_mcycle[63:32], nv};
                12'hB80: c_next = {nv, m_mcycle[31:0] + 32'd1};
                12'hB02: i_next = {m_minstret[63:32], nv};
                12'hB82: i_next = {nv, m_minstret[31:0] + (r ? 32'd1 : 32'd0)};
                default: ;
            endcase
        end
        m_mcycle   = c_next;
        m_minstret = i_next;
        @(negedge clk);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        logic il;
        cyc(1'b0, 3'd0, a, 5'd0, 32'd0, 1'b0, v, il);
    endtask

    initial begin
        rst_n = 0; CSRWrite = 0; funct3 = 0; CSRAddr = 0; Rs1Idx = 0; Rs1Data = 0; InstrRetired = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Reset state and free-running mcycle
        repeat (10) cyc(1'b0, 3'd0, 12'h000, 5'd0, 32'd0, 1'b0, rdv, ilv);
        rd(12'hB00, rdv); chk32("mcycle_after_10", rdv, 32'd10);
        rd(12'hC00, rdv); chk32("cycle_alias_11", rdv, 32'd11);
        rd(12'hB80, rdv); chk32("mcycleh_zero", rdv, 32'd0);
        rd(12'h305, rdv); chk32("mtvec_reset", rdv, 32'h8000_0104);

        // RW / RS / RC on mscratch
        cyc(1'b1, 3'b001, 12'h340, 5'd3, 32'hDEADBEEF, 1'b1, rdv, ilv);
        chk32("rw_old", rdv, 32'd0);
        cyc(1'b1, 3'b010, 12'h340, 5'd5, 32'h0000_00F0, 1'b1, rdv, ilv);
        chk32("rs_old", rdv, 32'hDEADBEEF);
        cyc(1'b1, 3'b011, 12'h340, 5'd0, 32'hFFFF_FFFF, 1'b1, rdv, ilv);
        chk32("rc_x0_old", rdv, 32'hDEADBEFF);
        rd(12'h340, rdv); chk32("rc_x0_nowrite", rdv, 32'hDEADBEFF);

        // Immediate form, alignment, illegal accesses
        cyc(1'b1, 3'b101, 12'h305, 5'h1F, 32'hFFFF_FFFF, 1'b0, rdv, ilv);
        rd(12'h305, rdv); chk32("mtvec_rwi", rdv, 32'h0000_001C);
        cyc(1'b1, 3'b001, 12'hC00, 5'd1, 32'h1234_5678, 1'b0, rdv, ilv);
        chk32("rw_ro_illegal", {31'd0, ilv}, 32'd1);
        cyc(1'b1, 3'b110, 12'hC00, 5'd0, 32'h0, 1'b0, rdv, ilv);
        chk32("rsi0_ro_legal", {31'd0, ilv}, 32'd0);
        cyc(1'b1, 3'b000, 12'h340, 5'd1, 32'h1, 1'b0, rdv, ilv);
        chk32("f3_000_illegal", {31'd0, ilv}, 32'd1);
        cyc(1'b1, 3'b001, 12'h123, 5'd1, 32'h1, 1'b0, rdv, ilv);
        chk32("unimpl_illegal", {31'd0, ilv}, 32'd1);
        cyc(1'b0, 3'b001, 12'h123, 5'd1, 32'h1, 1'b0, rdv, ilv);
        chk32("unimpl_nowrite_legal", {31'd0, ilv}, 32'd0);
        cyc(1'b1, 3'b001, 12'h341, 5'd1, 32'h0000_1003, 1'b0, rdv, ilv);
        rd(12'h341, rdv); chk32("mepc_align", rdv, 32'h0000_1000);

        // mcycle carry and high-half write priority
        cyc(1'b1, 3'b001, 12'hB80, 5'd1, 32'd0, 1'b0, rdv, ilv);
        cyc(1'b1, 3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, 1'b0, rdv, ilv);
        rd(12'hB00, rdv); chk32("mcycle_loaded", rdv, 32'hFFFF_FFFF);
        rd(12'hB80, rdv); chk32("mcycleh_carry", rdv, 32'd1);
        rd(12'hB00, rdv); chk32("mcycle_wrapped", rdv, 32'd1);
        cyc(1'b1, 3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, 1'b0, rdv, ilv);
        cyc(1'b1, 3'b001, 12'hB80, 5'd1, 32'd7, 1'b0, rdv, ilv);
        rd(12'hB80, rdv); chk32("mcycleh_no_carry", rdv, 32'd7);
        rd(12'hB00, rdv); chk32("mcycle_after_hiwr", rdv, 32'd1);

        // minstret full wrap and write-beats-retire
        cyc(1'b1, 3'b001, 12'hB02, 5'd1, 32'hFFFF_FFFF, 1'b0, rdv, ilv);
        cyc(1'b1, 3'b001, 12'hB82, 5'd1, 32'hFFFF_FFFF, 1'b0, rdv, ilv);
        cyc(1'b0, 3'b000, 12'h000, 5'd0, 32'd0, 1'b1, rdv, ilv);
        rd(12'hB02, rdv); chk32("minstret_wrap_lo", rdv, 32'd0);
        rd(12'hC82, rdv); chk32("minstret_wrap_hi", rdv, 32'd0);
        cyc(1'b1, 3'b001, 12'hB02, 5'd1, 32'd5, 1'b1, rdv, ilv);
        rd(12'hB02, rdv); chk32("minstret_write_wins", rdv, 32'd5);

        // Randomized ops against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] idx;
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            cyc(($urandom_range(0, 4) != 0), 3'($urandom), addrs[$urandom_range(0, 14)],
                idx, $urandom, 1'($urandom), rdv, ilv);
        end

        // Asynchronous reset between edges
        cyc(1'b1, 3'b001, 12'h340, 5'd1, 32'hCAFE_F00D, 1'b1, rdv, ilv);
        CSRWrite = 1; funct3 = 3'b001; CSRAddr = 12'h340; Rs1Idx = 5'd1; Rs1Data = 32'h1111_1111;
        #2 rst_n = 0;
        #1 chk32("async_rst_mscratch", CSRRead, 32'd0);
        CSRWrite = 0;
        model_reset();
        for (int k = 0; k < 12; k++) begin
            logic [31:0] e;
            bit im, r0;
            CSRAddr = addrs[k];
            #1;
            e = m_read(addrs[k], im, r0);
            chk32($sformatf("rst_val_%h", addrs[k]), CSRRead, e);
        end
        @(negedge clk);
        rst_n = 1;
        rd(12'hB00, rdv); chk32("mcycle_restart", rdv, 32'd0);
        rd(12'hB00, rdv); chk32("mcycle_first_inc", rdv, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode control/status register file for the single-cycle RV32 core, sitting directly downstream of the instruction-decode controller. Consumes the controller's `CSRWrite` strobe and the instruction's `funct3`/CSR-address/rs1 fields, returns the old CSR value for register writeback, and applies the read-modify-write at the clock edge. Owns the free-running 64-bit cycle and retired-instruction counters.

## Interface
- `MTVEC_RESET`, 32'h0000_0000, reset value of mtvec; bits [1:0] ignored, forced to 00
- `clk`  in  1  core clock; one clock domain; all state updates on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `CSRWrite`  in  1  controller strobe: current instruction is a Zicsr op
- `funct3`  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- `CSRAddr`  in  12  instr[31:20]
- `Rs1Idx`  in  5  instr[19:15]; also the zimm operand for the immediate forms
- `Rs1Data`  in  32  register-file read of rs1
- `InstrRetired`  in  1  current instruction completes this cycle
- `CSRRead`  out  32  old value of the addressed CSR; 0 for unimplemented addresses
- `IllegalCSR`  out  1  CSR access this cycle is illegal; no state change

## Operation
- Implemented CSRs: mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82. Read-only aliases: cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82.
- Operand: `Rs1Data` for funct3[2]=0; zero-extended `Rs1Idx` for funct3[2]=1.
- New value: RW → operand; RS → old | operand; RC → old & ~operand.
- Write suppression: RS/RC/RSI/RCI with `Rs1Idx`==0 perform no write. The access is a pure read and is legal even to read-only CSRs.
- `IllegalCSR`=1, combinational, only when `CSRWrite`=1 and one of the following holds:
  - funct3 is 000 or 100;
  - the address is unimplemented;
  - a non-suppressed write targets a read-only alias (0xC00–0xC82).
- When `IllegalCSR`=1, no CSR is written; counters still advance normally.
- mtvec and mepc store bits [1:0] as 00. mscratch and mcause store all 32 bits.
- mcycle: 64-bit counter; increments every cycle out of reset.
- minstret: 64-bit counter; increments in cycles with `InstrRetired`=1.
- Both counters wrap from 2^64−1 to 0.
- Write vs. increment in the same cycle:
  - write to the low half: low ← new value, high unchanged (no carry that cycle);
  - write to the high half: high ← new value, low increments normally, any carry out of low is discarded.
- A CSR instruction that retires while writing minstret: write wins, no increment.
- Reset values: all counters 0, mscratch/mepc/mcause 0, mtvec `MTVEC_RESET` & ~3.

## Timing
- `CSRRead` and `IllegalCSR` are combinational from the current inputs and state, zero latency. `CSRRead` always returns the pre-edge value, which gives CSR read-old semantics for rd writeback.
- All CSR writes and counter updates take effect at the rising `clk` edge that ends the instruction. A read in the following cycle returns the new value.
- `CSRRead` decodes `CSRAddr` even when `CSRWrite`=0. The controller ignores the value in that case.
- Assertion of `rst_n`=0 clears state immediately, regardless of `clk`, including mid-write. The first increment of mcycle happens at the first rising edge after `rst_n` deasserts.
- No handshake; one CSR op per cycle, no stalls.

## Structure
- `csr_pkg` holds:
  - localparams for all CSR addresses;
  - an enum for the funct3 CSR op encodings;
  - the mtvec/mepc alignment mask.
- Sub-module `csr_counter64`, instantiated twice (mcycle, minstret). Ports:
  - `inc`;
  - `wr_lo`, `wr_hi`, `wdata`;
  - `q[63:0]`.
  - Implements the write-vs-increment and carry-suppression rules above.
- Read mux and op/legality decode stay in `csr_unit`.

## Test plan
- Reset, then 10 idle cycles → read 0xB00 returns 10 (mcycle = 10 after 10 edges; also read via 0xC00). 0xB80 returns 0. mtvec reads `MTVEC_RESET` & ~3.
- CSRRW 0x340 with Rs1Data=0xDEADBEEF → `CSRRead`=0 that cycle; the next read of 0x340 returns 0xDEADBEEF.
- CSRRS 0x340 with Rs1Data=0x0000_00F0 after the previous step → returns 0xDEADBEEF, stores 0xDEADBEFF. Then CSRRC with Rs1Idx=0 → no write.
- CSRRWI 0x305 with zimm=5'h1F → mtvec reads 0x1C. CSRRW to 0xC00 → `IllegalCSR`=1, mcycle unaffected.
- Write mcycle=0xFFFF_FFFF while mcycleh=0 → after 1 cycle mcycleh=1, mcycle=0. Write mcycleh=7 in the same cycle low wraps → mcycleh=7, not 8.
- Preload minstret to 2^64−1 and pulse `InstrRetired` → both halves wrap to 0.
- Assert `rst_n` mid-sequence between edges → all CSRs read reset values immediately.
